// File: rtl/issue_queue_if.sv
// Issue queue handshake bundle: decode-side push port and reservation-station issue port.
// The master modport is the environment (decode and reservation station); slave is the queue.
`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface issue_queue_if;
   logic                   in_valid;
   logic [2:0]             in_unit;
   logic [`REG_SIZE-1:0]   in_reg1;
   logic [`REG_SIZE-1:0]   in_reg2;
   logic [`REG_SIZE-1:0]   in_reg3;
   logic                   in_hasimm;
   logic [`WORD_SIZE-1:0]  in_imm;
   logic                   in_ready;

   logic                   rs_enable;
   logic [2:0]             rs_unit;
   logic [`REG_SIZE-1:0]   rs_reg1;
   logic [`REG_SIZE-1:0]   rs_reg2;
   logic [`REG_SIZE-1:0]   rs_reg3;
   logic                   rs_hasimm;
   logic [`WORD_SIZE-1:0]  rs_imm;
   logic                   rs_accept;

   modport master (
      output in_valid, in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm,
      input  in_ready,
      input  rs_enable, rs_unit, rs_reg1, rs_reg2, rs_reg3, rs_hasimm, rs_imm,
      output rs_accept
   );

   modport slave (
      input  in_valid, in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm,
      output in_ready,
      output rs_enable, rs_unit, rs_reg1, rs_reg2, rs_reg3, rs_hasimm, rs_imm,
      input  rs_accept
   );
endinterface

// File: rtl/issue_queue.sv
// Issue queue: circular FIFO of decoded instructions feeding a reservation station through an
// IDLE -> ISSUE -> WAIT handshake that retries until the station accepts.
// Optional macro ISSUE_QUEUE_STATS_EN builds a saturating retry counter on stall_count.
`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module issue_queue #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   issue_queue_if.slave           bus,
   output logic [$clog2(DEPTH):0] count,
   output logic [15:0]            stall_count
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef struct packed {
      logic [2:0]            unit;
      logic [`REG_SIZE-1:0]  reg1;
      logic [`REG_SIZE-1:0]  reg2;
      logic [`REG_SIZE-1:0]  reg3;
      logic                  hasimm;
      logic [`WORD_SIZE-1:0] imm;
   } entry_t;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   entry_t          mem_q [DEPTH];
   entry_t          head, in_entry;
   entry_t          rs_q, rs_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   state_e          state_q, state_d;
   logic            full, push, pop;

   // Ready comes from registered occupancy only, so a same-cycle pop never frees a full queue.
   assign full         = (count_q == CntW'(DEPTH));
   assign bus.in_ready = ~full;
   assign push         = rst_n & bus.in_valid & ~full;
   assign head         = mem_q[rd_ptr_q];
   assign in_entry     = '{unit: bus.in_unit, reg1: bus.in_reg1, reg2: bus.in_reg2,
                           reg3: bus.in_reg3, hasimm: bus.in_hasimm, imm: bus.in_imm};

   // Issue handshake: latch head, present it for one cycle, then pop or retry.
   always_comb begin
      state_d = state_q;
      rs_d    = rs_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               if (head.unit <= 3'b100) begin
                  rs_d    = head;
                  state_d = StIssue;
               end else begin
                  // Units 5..7 have no station; drop them silently.
                  pop = 1'b1;
               end
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (bus.rs_accept) begin
               pop     = 1'b1;
               state_d = StIdle;
            end else begin
               state_d = StIssue;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rs_q     <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         rs_q     <= rs_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_entry;
   end

   assign count         = count_q;
   assign bus.rs_enable = (state_q == StIssue);
   assign bus.rs_unit   = rs_q.unit;
   assign bus.rs_reg1   = rs_q.reg1;
   assign bus.rs_reg2   = rs_q.reg2;
   assign bus.rs_reg3   = rs_q.reg3;
   assign bus.rs_hasimm = rs_q.hasimm;
   assign bus.rs_imm    = rs_q.imm;

`ifdef ISSUE_QUEUE_STATS_EN
   logic        stall;
   logic [15:0] stall_count_q, stall_count_d;

   assign stall = (state_q == StWait) & ~bus.rs_accept;

   // Count refused issue attempts, saturating.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
   end

   // Retry counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) stall_count_q <= '0;
      else        stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;
`else
   assign stall_count = '0;
`endif
endmodule
